result_collector: RTL and testbench

- Sits directly downstream of the execution units (integer unit and siblings).
- Accepts one completed result per execution unit over a valid/ready handshake and buffers it in a per-unit holding slot.
- Arbitrates round-robin for the single register-file write port.
- Emits a registered tag-release pulse so the dispatcher/scoreboard can free the instruction ID.

---
 rtl/bgpu_pkg.sv | 30 +++
 rtl/rr_lock_arbiter.sv | 71 +++++++
 rtl/result_collector.sv | 121 ++++++++++++
 tb/tb_result_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bgpu_pkg.sv
// Shared types for the compute-unit back end: result slot layout and
// instruction-ID helpers used by the result and operand collectors.
package bgpu_pkg;

    localparam int NumTags     = 8;
    localparam int RegWidth    = 32;
    localparam int WarpWidth   = 4;
    localparam int NumWarps    = 8;
    localparam int RegIdxWidth = 8;
    localparam int TagWidth    = $clog2(NumTags);
    localparam int WidWidth    = NumWarps > 1 ? $clog2(NumWarps) : 1;
    localparam int DataWidth   = RegWidth * WarpWidth;

    typedef logic [TagWidth+WidWidth-1:0] iid_t;
    typedef logic [WidWidth-1:0]          wid_t;
    typedef logic [RegIdxWidth-1:0]       reg_idx_t;
    typedef logic [DataWidth-1:0]         data_t;

    typedef struct packed {
        iid_t     iid;
        reg_idx_t dst;
        data_t    data;
    } rc_slot_t;

    // The warp ID occupies the low bits of the instruction ID.
    function automatic wid_t iid_to_wid(input iid_t iid);
        return wid_t'(iid);
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that freezes its grant while the downstream consumer
// stalls, so the presented request stays stable until it is accepted.
module rr_lock_arbiter #(
    parameter int  NumEus   = 3,
    localparam int IdxWidth = NumEus > 1 ? $clog2(NumEus) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumEus-1:0]   req_i,
    input  logic                ready_i,
    output logic [NumEus-1:0]   gnt_o,
    output logic [IdxWidth-1:0] gnt_idx_o
);

    logic [IdxWidth-1:0] ptr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic [IdxWidth-1:0] search_idx;
    logic [IdxWidth-1:0] next_ptr;
    logic                lock_q;
    logic                any_req;
    logic                handshake;

    assign any_req   = |req_i;
    assign handshake = any_req & ready_i;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        int  cand;
        logic found;
        search_idx = ptr_q;
        found      = 1'b0;
        cand       = 0;
        for (int off = 0; off < NumEus; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NumEus) begin
                cand = cand - NumEus;
            end
            if (!found && req_i[cand]) begin
                found      = 1'b1;
                search_idx = IdxWidth'(cand);
            end
        end
    end

    always_comb begin
        gnt_idx_o = lock_q ? lock_idx_q : search_idx;
        for (int i = 0; i < NumEus; i++) begin
            gnt_o[i] = any_req && (gnt_idx_o == IdxWidth'(i));
        end
        if (gnt_idx_o == IdxWidth'(NumEus - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx_o + IdxWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (handshake) begin
            ptr_q  <= next_ptr;
            lock_q <= 1'b0;
        end else if (any_req) begin
            lock_q     <= 1'b1;
            lock_idx_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/result_collector.sv
// Buffers one completed result per execution unit and drains them round-robin
// into the register-file write port. Optional counters: RESULT_COLLECTOR_STATS_EN.
module result_collector
    import bgpu_pkg::*;
#(
    parameter int  NumEus   = 3,
    localparam int IdxWidth = NumEus > 1 ? $clog2(NumEus) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumEus-1:0]             eu_to_rc_valid_i,
    output logic [NumEus-1:0]             rc_to_eu_ready_o,
    input  iid_t [NumEus-1:0]             eu_to_rc_tag_i,
    input  reg_idx_t [NumEus-1:0]         eu_to_rc_dst_i,
    input  data_t [NumEus-1:0]            eu_to_rc_data_i,
    output logic                          rc_to_rf_valid_o,
    input  logic                          rf_to_rc_ready_i,
    output logic [WidWidth-1:0]           rc_to_rf_wid_o,
    output logic [RegIdxWidth-1:0]        rc_to_rf_dst_o,
    output logic [DataWidth-1:0]          rc_to_rf_data_o,
    output logic                          rc_to_wb_valid_o,
    output iid_t                          rc_to_wb_iid_o
`ifdef RESULT_COLLECTOR_STATS_EN
    ,
    output logic [NumEus-1:0][31:0]       stats_wb_count_o,
    output logic [31:0]                   stats_stall_count_o
`endif
);

    rc_slot_t [NumEus-1:0] slot_q;
    logic [NumEus-1:0]     slot_valid_q;
    logic [NumEus-1:0]     gnt;
    logic [IdxWidth-1:0]   gnt_idx;
    rc_slot_t              granted;
    logic                  any_valid;
    logic                  rf_hs;

    rr_lock_arbiter #(
        .NumEus (NumEus)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (slot_valid_q),
        .ready_i   (rf_to_rc_ready_i),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign any_valid = |slot_valid_q;
    assign rf_hs     = any_valid & rf_to_rc_ready_i;

    // A slot accepts when empty or when it is being drained this very cycle.
    always_comb begin
        for (int i = 0; i < NumEus; i++) begin
            rc_to_eu_ready_o[i] = !slot_valid_q[i] || (gnt[i] && rf_hs);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            slot_q       <= '0;
        end else begin
            for (int i = 0; i < NumEus; i++) begin
                if (rc_to_eu_ready_o[i] && eu_to_rc_valid_i[i]) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_q[i]       <= '{iid:  eu_to_rc_tag_i[i],
                                         dst:  eu_to_rc_dst_i[i],
                                         data: eu_to_rc_data_i[i]};
                end else if (gnt[i] && rf_hs) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        granted          = slot_q[gnt_idx];
        rc_to_rf_valid_o = any_valid;
        rc_to_rf_wid_o   = '0;
        rc_to_rf_dst_o   = '0;
        rc_to_rf_data_o  = '0;
        if (any_valid) begin
            rc_to_rf_wid_o  = iid_to_wid(granted.iid);
            rc_to_rf_dst_o  = granted.dst;
            rc_to_rf_data_o = granted.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rc_to_wb_valid_o <= 1'b0;
            rc_to_wb_iid_o   <= '0;
        end else begin
            rc_to_wb_valid_o <= rf_hs;
            if (rf_hs) begin
                rc_to_wb_iid_o <= granted.iid;
            end
        end
    end

`ifdef RESULT_COLLECTOR_STATS_EN
    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stats_wb_count_o    <= '0;
            stats_stall_count_o <= '0;
        end else begin
            for (int i = 0; i < NumEus; i++) begin
                if (gnt[i] && rf_hs && stats_wb_count_o[i] != '1) begin
                    stats_wb_count_o[i] <= stats_wb_count_o[i] + 32'd1;
                end
            end
            if (any_valid && !rf_to_rc_ready_i && stats_stall_count_o != '1) begin
                stats_stall_count_o <= stats_stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector; stats checks compile in with
// RESULT_COLLECTOR_STATS_EN.
module tb_result_collector;
    import bgpu_pkg::*;

    localparam int NumEus = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NumEus-1:0]     eu_valid;
    logic [NumEus-1:0]     eu_ready;
    iid_t [NumEus-1:0]     eu_tag;
    reg_idx_t [NumEus-1:0] eu_dst;
    data_t [NumEus-1:0]    eu_data;
    logic                  rf_valid;
    logic                  rf_ready;
    wid_t                  rf_wid;
    reg_idx_t              rf_dst;
    data_t                 rf_data;
    logic                  wb_valid;
    iid_t                  wb_iid;
`ifdef RESULT_COLLECTOR_STATS_EN
    logic [NumEus-1:0][31:0] stats_wb;
    logic [31:0]             stats_stall;
`endif

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        seq = 0;
    rc_slot_t  drive_q[NumEus][$];
    rc_slot_t  exp_q[NumEus][$];
    int        grant_log[$];
    int        grant_cyc[$];
    logic [NumEus-1:0] acc = '0;
    logic      rel_pending = 1'b0;
    iid_t      rel_iid = '0;

    always #5 clk = ~clk;

    result_collector #(
        .NumEus (NumEus)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .eu_to_rc_valid_i (eu_valid),
        .rc_to_eu_ready_o (eu_ready),
        .eu_to_rc_tag_i   (eu_tag),
        .eu_to_rc_dst_i   (eu_dst),
        .eu_to_rc_data_i  (eu_data),
        .rc_to_rf_valid_o (rf_valid),
        .rf_to_rc_ready_i (rf_ready),
        .rc_to_rf_wid_o   (rf_wid),
        .rc_to_rf_dst_o   (rf_dst),
        .rc_to_rf_data_o  (rf_data),
        .rc_to_wb_valid_o (wb_valid),
        .rc_to_wb_iid_o   (wb_iid)
`ifdef RESULT_COLLECTOR_STATS_EN
        ,
        .stats_wb_count_o    (stats_wb),
        .stats_stall_count_o (stats_stall)
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // The destination's upper nibble records which unit produced the result.
    function automatic rc_slot_t mkItem(input int eu);
        rc_slot_t s;
        seq++;
        s.iid  = iid_t'($urandom);
        s.dst  = reg_idx_t'((eu << 4) | (seq & 15));
        s.data = {$urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    function automatic int busyCount();
        int n = 0;
        for (int i = 0; i < NumEus; i++) begin
            n += drive_q[i].size() + exp_q[i].size() + int'(eu_valid[i]);
        end
        return n + int'(rf_valid);
    endfunction

    task automatic applyStimulus(input int eu, input rc_slot_t it);
        drive_q[eu].push_back(it);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (busyCount() == 0) return;
        end
        checkOutput("idle_timeout", busyCount(), 0);
    endtask

    // Monitor: release pulses, register-file writes and accepted results.
    always @(negedge clk) begin
        int eu;
        rc_slot_t e;
        cyc++;
        if (rel_pending) begin
            checkOutput("wb_valid", wb_valid, 1);
            checkOutput("wb_iid", wb_iid, rel_iid);
        end else begin
            checkOutput("wb_idle", wb_valid, 0);
        end
        rel_pending = 1'b0;
        acc = '0;
        if (rst) begin
            for (int i = 0; i < NumEus; i++) exp_q[i].delete();
        end else begin
            if (rf_valid && rf_ready) begin
                eu = int'(rf_dst[7:4]);
                if (eu >= NumEus || exp_q[eu].size() == 0) begin
                    checkOutput("rf_unexpected_write", rf_valid, 0);
                end else begin
                    e = exp_q[eu].pop_front();
                    checkOutput("rf_wid", rf_wid, e.iid % NumWarps);
                    checkOutput("rf_dst", rf_dst, e.dst);
                    checkOutput("rf_data", rf_data, e.data);
                    rel_pending = 1'b1;
                    rel_iid     = e.iid;
                    grant_log.push_back(eu);
                    grant_cyc.push_back(cyc);
                end
            end
            for (int i = 0; i < NumEus; i++) begin
                if (eu_valid[i] && eu_ready[i]) begin
                    acc[i] = 1'b1;
                    exp_q[i].push_back('{iid: eu_tag[i], dst: eu_dst[i], data: eu_data[i]});
                end
            end
        end
    end

    // Driver: each unit holds its result until the collector takes it.
    always @(posedge clk) begin
        rc_slot_t it;
        #1;
        for (int i = 0; i < NumEus; i++) begin
            if (!eu_valid[i] || acc[i]) begin
                if (drive_q[i].size() > 0) begin
                    it = drive_q[i].pop_front();
                    eu_valid[i] = 1'b1;
                    eu_tag[i]   = it.iid;
                    eu_dst[i]   = it.dst;
                    eu_data[i]  = it.data;
                end else begin
                    eu_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        rc_slot_t held;
        rc_slot_t a;
        rc_slot_t b;
        bit ok;

        rst      = 1'b1;
        rf_ready = 1'b0;
        eu_valid = '0;
        eu_tag   = '0;
        eu_dst   = '0;
        eu_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rf_valid", rf_valid, 0);
        checkOutput("rst_ready", eu_ready, 3'b111);
        checkOutput("rst_wid", rf_wid, 0);
        checkOutput("rst_dst", rf_dst, 0);
        checkOutput("rst_data", rf_data, 0);
        checkOutput("rst_wb_iid", wb_iid, 0);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef RESULT_COLLECTOR_STATS_EN
        @(negedge clk);
        checkOutput("stats_rst_wb0", stats_wb[0], 0);
        checkOutput("stats_rst_stall", stats_stall, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, mkItem(0));
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rf_valid;
        end
        checkOutput("stats_wait_valid", ok, 1);
        repeat (3) @(posedge clk);
        #1 rf_ready = 1'b1;
        waitIdle();
        checkOutput("stats_wb0", stats_wb[0], 5);
        checkOutput("stats_wb1", stats_wb[1], 0);
        checkOutput("stats_stall", stats_stall, 3);
`endif

        // Single result: RF write one cycle after acceptance, release one cycle later.
        @(posedge clk);
        #1 rf_ready = 1'b1;
        @(negedge clk);
        applyStimulus(0, '{iid: iid_t'(8'h0A), dst: reg_idx_t'(5), data: data_t'(1)});
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = eu_valid[0] && eu_ready[0];
        end
        checkOutput("t1_accept", ok, 1);
        @(negedge clk);
        checkOutput("t1_rf_valid", rf_valid, 1);
        checkOutput("t1_wid", rf_wid, 2);
        checkOutput("t1_dst", rf_dst, 5);
        checkOutput("t1_data", rf_data, 1);
        @(negedge clk);
        checkOutput("t1_wb_valid", wb_valid, 1);
        checkOutput("t1_wb_iid", wb_iid, 8'h0A);
        @(negedge clk);
        checkOutput("t1_wb_pulse_end", wb_valid, 0);
        waitIdle();

        // All units streaming: the pointer sits at 1 after the EU0 write above.
        grant_log.delete();
        grant_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NumEus; i++) applyStimulus(i, mkItem(i));
        end
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = grant_log.size() >= 6;
        end
        checkOutput("t2_six_grants", ok, 1);
        if (ok) begin
            for (int k = 0; k < 6; k++) begin
                checkOutput("t2_rr_order", grant_log[k], (1 + k) % 3);
                checkOutput("t2_back_to_back", grant_cyc[k] - grant_cyc[0], k);
            end
        end
        waitIdle();

        // Move the pointer to 2, then stall with EU1 granted while EU2/EU0 arrive.
        applyStimulus(1, mkItem(1));
        waitIdle();
        @(posedge clk);
        #1 rf_ready = 1'b0;
        @(negedge clk);
        held = mkItem(1);
        applyStimulus(1, held);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rf_valid;
        end
        checkOutput("t3_wait_valid", ok, 1);
        applyStimulus(2, mkItem(2));
        applyStimulus(0, mkItem(0));
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("t3_lock_dst", rf_dst, held.dst);
            checkOutput("t3_lock_data", rf_data, held.data);
            checkOutput("t3_lock_wid", rf_wid, held.iid % NumWarps);
        end
        @(posedge clk);
        #1 rf_ready = 1'b1;
        waitIdle();
        checkOutput("t3_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            checkOutput("t3_order0", grant_log[0], 1);
            checkOutput("t3_order1", grant_log[1], 2);
            checkOutput("t3_order2", grant_log[2], 0);
        end

        // Slot 2 full under stall holds the next EU2 result off until drain.
        @(posedge clk);
        #1 rf_ready = 1'b0;
        @(negedge clk);
        a = mkItem(2);
        b = mkItem(2);
        applyStimulus(2, a);
        applyStimulus(2, b);
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = rf_valid && eu_valid[2] && (eu_dst[2] == b.dst);
        end
        checkOutput("t4_wait_second", ok, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("t4_ready_low", eu_ready[2], 0);
            checkOutput("t4_hold_dst", rf_dst, a.dst);
        end
        @(posedge clk);
        #1 rf_ready = 1'b1;
        @(negedge clk);
        checkOutput("t4_drain_refill_ready", eu_ready[2], 1);
        @(negedge clk);
        checkOutput("t4_refill_valid", rf_valid, 1);
        checkOutput("t4_refill_dst", rf_dst, b.dst);
        waitIdle();

        // Reset with two slots full under stall; the pointer is 1 beforehand.
        applyStimulus(0, mkItem(0));
        waitIdle();
        @(posedge clk);
        #1 rf_ready = 1'b0;
        @(negedge clk);
        applyStimulus(0, mkItem(0));
        applyStimulus(1, mkItem(1));
        ok = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = !eu_ready[0] && !eu_ready[1];
        end
        checkOutput("t5_both_full", ok, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rf_valid", rf_valid, 0);
        checkOutput("t5_ready", eu_ready, 3'b111);
        checkOutput("t5_dst", rf_dst, 0);
`ifdef RESULT_COLLECTOR_STATS_EN
        checkOutput("t5_stats_wb0", stats_wb[0], 0);
        checkOutput("t5_stats_stall", stats_stall, 0);
`endif
        @(posedge clk);
        #1 rf_ready = 1'b1;
        @(negedge clk);
        grant_log.delete();
        for (int i = 0; i < NumEus; i++) applyStimulus(i, mkItem(i));
        waitIdle();
        checkOutput("t5_grant_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            for (int k = 0; k < 3; k++) checkOutput("t5_ptr_reset_order", grant_log[k], k);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
